// File: rtl/delay_tap_mixer.sv
// delay_tap_mixer: registers the delay-line tap select, mixes the live sample
// with the selected delayed sample into a saturated echo, and mutes the wet
// term while a newly selected delay line refills.
//
// Optional feature macro: MIX_PEAK_EN (peak hold on peak_out, cleared by peak_clr).
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   tap_sel / tap_sel_q  requested tap / registered tap driving the line mux
//   gain                 wet gain, wet = (in_dly * gain) >> GAIN_W
//   in_valid/in_ready    input handshake for the live/delayed pair
//   in_live, in_dly      dry sample and delayed sample
//   out_valid/out_ready  output handshake
//   out_data             saturated mix
//   muted                high while the tap FSM is refilling (MUTE)
//   peak_out, peak_clr   peak hold of transferred outputs and its clear
module delay_tap_mixer #(
    parameter int WIDTH       = 8,
    parameter int GAIN_W      = 3,
    parameter int MUTE_CYCLES = 90
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        tap_sel,
    output logic [1:0]        tap_sel_q,
    input  logic [GAIN_W-1:0] gain,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_live,
    input  logic [WIDTH-1:0]  in_dly,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              muted,
    output logic [WIDTH-1:0]  peak_out,
    input  logic              peak_clr
);

    localparam int PW    = WIDTH + GAIN_W;
    localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUTE_CYCLES - 1);

    typedef enum logic {
        RUN  = 1'b0,
        MUTE = 1'b1
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    // Tap FSM. The counter runs on every clock regardless of the stream
    // handshake because the delay lines shift every clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MUTE;
            cnt_q     <= CNT_LOAD;
            tap_sel_q <= 2'd0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (tap_sel != tap_sel_q) begin
                        tap_sel_q <= tap_sel;
                        cnt_q     <= CNT_LOAD;
                        state_q   <= MUTE;
                    end
                end
                MUTE: begin
                    if (tap_sel != tap_sel_q) begin
                        // Restart the refill window for the new line.
                        tap_sel_q <= tap_sel;
                        cnt_q     <= CNT_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= MUTE;
            endcase
        end
    end

    assign muted = (state_q == MUTE);

    // Stream pipeline
    logic             stall;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_live_q;
    logic [PW-1:0]    s1_prod_q;
    logic [PW-1:0]    prod_d;
    logic [WIDTH:0]   sum_d;
    logic [WIDTH-1:0] sat_d;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;

    // Mute decision is taken at accept; in-flight samples keep their wet term.
    assign prod_d = muted ? '0 : (PW'(in_dly) * PW'(gain));

    assign sum_d = {1'b0, s1_live_q} + {1'b0, s1_prod_q[PW-1:GAIN_W]};
    assign sat_d = sum_d[WIDTH] ? {WIDTH{1'b1}} : sum_d[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_live_q   <= '0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_live_q <= in_live;
                s1_prod_q <= prod_d;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q <= sat_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef MIX_PEAK_EN
    logic             xfer;
    logic [WIDTH-1:0] peak_q;

    assign xfer = out_valid_q && out_ready;

    // A clear coinciding with a transfer restarts the peak at that value.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= xfer ? out_data_q : '0;
        end else if (xfer && (out_data_q > peak_q)) begin
            peak_q <= out_data_q;
        end
    end

    assign peak_out = peak_q;
`else
    logic unused_peak_clr;
    assign unused_peak_clr = peak_clr;
    assign peak_out        = '0;
`endif

endmodule

// File: tb/tb_delay_tap_mixer.sv
// Directed testbench for delay_tap_mixer.
// One task per scenario, each with inline expected-value checks.
module tb_delay_tap_mixer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] tap_sel;
    logic [1:0] tap_sel_q;
    logic [2:0] gain;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_live;
    logic [7:0] in_dly;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       muted;
    logic [7:0] peak_out;
    logic       peak_clr;

    int tests = 0;
    int fails = 0;

    delay_tap_mixer dut (
        .clk       (clk),
        .rst       (rst),
        .tap_sel   (tap_sel),
        .tap_sel_q (tap_sel_q),
        .gain      (gain),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_live   (in_live),
        .in_dly    (in_dly),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .muted     (muted),
        .peak_out  (peak_out),
        .peak_clr  (peak_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tap_sel = 2'd0; gain = 3'd4;
        in_valid = 1'b1; in_live = 8'd100; in_dly = 8'd200;
        out_ready = 1'b1; peak_clr = 1'b0;
        step(); step();
        tests++;
        if (tap_sel_q !== 2'd0) begin
            fails++; $display("FAIL reset_tap got %0d exp 0", tap_sel_q);
        end
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid got %0b exp 0", out_valid);
        end
        tests++;
        if (out_data !== 8'd0) begin
            fails++; $display("FAIL reset_out_data got %0d exp 0", out_data);
        end
        tests++;
        if (muted !== 1'b1) begin
            fails++; $display("FAIL reset_muted got %0b exp 1", muted);
        end
        tests++;
        if (peak_out !== 8'd0) begin
            fails++; $display("FAIL reset_peak got %0d exp 0", peak_out);
        end
    endtask

    // Cycle 0 is the first cycle after reset release.
    task automatic test_startup_mute();
        logic [7:0] exp_d;
        rst = 1'b0;
        for (int cyc = 0; cyc < 96; cyc++) begin
            tests++;
            if (muted !== (cyc < 90)) begin
                fails++;
                $display("FAIL startup_muted cyc %0d got %0b exp %0b",
                         cyc, muted, (cyc < 90));
            end
            if (cyc < 2) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL startup_fill cyc %0d got valid %0b exp 0",
                             cyc, out_valid);
                end
            end else begin
                exp_d = (cyc >= 92) ? 8'd200 : 8'd100;
                tests++;
                if (out_valid !== 1'b1 || out_data !== exp_d) begin
                    fails++;
                    $display("FAIL startup_data cyc %0d got %0d/%0b exp %0d/1",
                             cyc, out_data, out_valid, exp_d);
                end
            end
            step();
        end
    endtask

    task automatic test_mix();
        in_valid = 1'b1;
        in_live = 8'd200; in_dly = 8'd255; gain = 3'd7;
        step();
        in_live = 8'd10; in_dly = 8'd16; gain = 3'd1;
        step();
        in_live = 8'd77; in_dly = 8'd250; gain = 3'd0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd255) begin
            fails++; $display("FAIL mix_sat got %0d exp 255", out_data);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd12) begin
            fails++; $display("FAIL mix_small got %0d exp 12", out_data);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd77) begin
            fails++; $display("FAIL mix_dry got %0d exp 77", out_data);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'd77) begin
            fails++;
            $display("FAIL mix_bubble got %0d/%0b exp 77/0", out_data, out_valid);
        end
    endtask

    task automatic test_stall();
        gain = 3'd0; in_valid = 1'b1; in_live = 8'd30;
        step();
        in_live = 8'd40;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd30) begin
                fails++;
                $display("FAIL stall_hold i %0d got rdy %0b data %0d exp 0/30",
                         i, in_ready, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_data !== 8'd30) begin
            fails++;
            $display("FAIL stall_release got rdy %0b data %0d exp 1/30",
                     in_ready, out_data);
        end
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd40) begin
            fails++; $display("FAIL stall_drain2 got %0d exp 40", out_data);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL stall_nodup got valid %0b exp 0", out_valid);
        end
    endtask

    task automatic test_tap_change();
        int run_len;
        tests++;
        if (muted !== 1'b0) begin
            fails++; $display("FAIL tap_prerun got %0b exp 0", muted);
        end
        tap_sel = 2'd2;
        step();
        tests++;
        if (tap_sel_q !== 2'd2 || muted !== 1'b1) begin
            fails++;
            $display("FAIL tap_first got %0d/%0b exp 2/1", tap_sel_q, muted);
        end
        // Walk to the cycle where the counter reads 40.
        for (int i = 0; i < 49; i++) begin
            step();
            tests++;
            if (muted !== 1'b1) begin
                fails++; $display("FAIL tap_mute1 i %0d got 0 exp 1", i);
            end
        end
        tap_sel = 2'd3;
        step();
        tests++;
        if (tap_sel_q !== 2'd3) begin
            fails++; $display("FAIL tap_second got %0d exp 3", tap_sel_q);
        end
        run_len = 0;
        while (muted === 1'b1 && run_len < 200) begin
            run_len++;
            step();
        end
        tests++;
        if (run_len !== 90) begin
            fails++; $display("FAIL tap_restart_len got %0d exp 90", run_len);
        end
    endtask

    task automatic test_reset_mid();
        gain = 3'd0; in_valid = 1'b1; in_live = 8'd5; out_ready = 1'b1;
        step(); step(); step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd5) begin
            fails++; $display("FAIL rmid_pre got %0d/%0b exp 5/1", out_data, out_valid);
        end
        rst = 1'b1;
        tap_sel = 2'd1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || muted !== 1'b1 ||
            tap_sel_q !== 2'd0) begin
            fails++;
            $display("FAIL rmid_state got v%0b d%0d m%0b t%0d exp v0 d0 m1 t0",
                     out_valid, out_data, muted, tap_sel_q);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || tap_sel_q !== 2'd1 || muted !== 1'b1) begin
            fails++;
            $display("FAIL rmid_after got v%0b t%0d m%0b exp v0 t1 m1",
                     out_valid, tap_sel_q, muted);
        end
    endtask

    task automatic test_peak();
        gain = 3'd0; out_ready = 1'b1; peak_clr = 1'b0;
        in_valid = 1'b1; in_live = 8'd50;
        step();
        in_live = 8'd180;
        step();
        in_live = 8'd90;
        step();
        in_valid = 1'b0;
        step(); step(); step();
`ifdef MIX_PEAK_EN
        tests++;
        if (peak_out !== 8'd180) begin
            fails++; $display("FAIL peak_max got %0d exp 180", peak_out);
        end
`else
        tests++;
        if (peak_out !== 8'd0) begin
            fails++; $display("FAIL peak_tied got %0d exp 0", peak_out);
        end
`endif
        in_valid = 1'b1; in_live = 8'd70;
        step();
        in_valid = 1'b0;
        step();
        peak_clr = 1'b1;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'd70) begin
            fails++; $display("FAIL peak_src got %0d exp 70", out_data);
        end
        step();
        peak_clr = 1'b0;
`ifdef MIX_PEAK_EN
        tests++;
        if (peak_out !== 8'd70) begin
            fails++; $display("FAIL peak_clr_xfer got %0d exp 70", peak_out);
        end
`else
        tests++;
        if (peak_out !== 8'd0) begin
            fails++; $display("FAIL peak_tied2 got %0d exp 0", peak_out);
        end
`endif
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        tests++;
        if (peak_out !== 8'd0) begin
            fails++; $display("FAIL peak_clr got %0d exp 0", peak_out);
        end
    endtask

    initial begin
        test_reset();
        test_startup_mute();
        test_mix();
        test_stall();
        test_tap_change();
        test_reset_mid();
        test_peak();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
